// File: rtl/fifo_pkg.sv
// Shared Gray/binary helpers and depth constant for both sides of the dual-clock FIFO.
// The helpers work on 32-bit values, so any narrower pointer can be zero-extended in and truncated out.
package fifo_pkg;

    localparam int FIFO_ADDRSIZEL = 4;
    localparam int FIFO_DEPTH     = 1 << FIFO_ADDRSIZEL;

    function automatic logic [31:0] bin2gray(input logic [31:0] x);
        return x ^ (x >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] x);
        logic [31:0] b;
        b[31] = x[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ x[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/rptr_empty_gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or above it.
module rptr_empty_gray2bin #(
    parameter int W = 5
) (
    input  logic [W-1:0] i_gray,
    output logic [W-1:0] o_bin
);

    always_comb begin
        o_bin        = '0;
        o_bin[W-1]   = i_gray[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            o_bin[i] = o_bin[i+1] ^ i_gray[i];
        end
    end

endmodule

// File: rtl/rptr_empty.sv
// Read-domain pointer and flag logic for the dual-clock FIFO: binary/Gray read pointer,
// RAM read address, registered empty/almost-empty, fill level and sticky underflow.
module rptr_empty #(
    parameter int ADDRSIZEL     = 4,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic                 rinc,
    input  logic                 rundf_clr,
    input  logic [ADDRSIZEL:0]   rq2_wptr,
    output logic [ADDRSIZEL:0]   rptr,
    output logic [ADDRSIZEL-1:0] raddr,
    output logic                 rempty,
    output logic                 raempty,
    output logic [ADDRSIZEL:0]   rlevel,
    output logic                 rundf
);
    import fifo_pkg::*;

    localparam int PTR_W = ADDRSIZEL + 1;

    logic [PTR_W-1:0] r_rbin;
    logic [PTR_W-1:0] r_rptr;
    logic             r_rempty;
    logic             r_raempty;
    logic [PTR_W-1:0] r_rlevel;
    logic             r_rundf;

    logic [PTR_W-1:0] w_rbnext;
    logic [PTR_W-1:0] w_rgnext;
    logic [PTR_W-1:0] w_wbin;
    logic [PTR_W-1:0] w_lvl_next;
    logic             w_undf;

    rptr_empty_gray2bin #(
        .W (PTR_W)
    ) u_wptr_g2b (
        .i_gray (rq2_wptr),
        .o_bin  (w_wbin)
    );

    // A read only commits while the FIFO is known non-empty; otherwise it is an underflow.
    assign w_undf     = rinc & r_rempty;
    assign w_rbnext   = r_rbin + PTR_W'(rinc & ~r_rempty);
    assign w_rgnext   = PTR_W'(bin2gray(32'(w_rbnext)));
    // Level uses the post-read pointer so flags match the state after this edge.
    assign w_lvl_next = w_wbin - w_rbnext;

    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_rbin    <= '0;
            r_rptr    <= '0;
            r_rempty  <= 1'b1;
            r_raempty <= 1'b1;
            r_rlevel  <= '0;
            r_rundf   <= 1'b0;
        end else begin
            r_rbin    <= w_rbnext;
            r_rptr    <= w_rgnext;
            r_rempty  <= (w_rgnext == rq2_wptr);
            r_raempty <= (w_lvl_next <= PTR_W'(AEMPTY_THRESH));
            r_rlevel  <= w_lvl_next;
            if (w_undf) begin
                r_rundf <= 1'b1;
            end else if (rundf_clr) begin
                r_rundf <= 1'b0;
            end
        end
    end

    assign rptr    = r_rptr;
    assign raddr   = r_rbin[ADDRSIZEL-1:0];
    assign rempty  = r_rempty;
    assign raempty = r_raempty;
    assign rlevel  = r_rlevel;
    assign rundf   = r_rundf;

endmodule

// File: tb/tb_rptr_empty.sv
// Directed-vector scoreboard bench for rptr_empty (ADDRSIZEL=4, AEMPTY_THRESH=2).
module tb_rptr_empty;

    logic       rclk = 1'b0;
    logic       rrst;
    logic       rinc;
    logic       rundf_clr;
    logic [4:0] rq2_wptr;
    logic [4:0] rptr;
    logic [3:0] raddr;
    logic       rempty;
    logic       raempty;
    logic [4:0] rlevel;
    logic       rundf;

    typedef struct {
        logic [4:0] rptr;
        logic [3:0] raddr;
        logic       rempty;
        logic       raempty;
        logic [4:0] rlevel;
        logic       rundf;
        int         id;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   vec_id = 0;

    rptr_empty #(
        .ADDRSIZEL     (4),
        .AEMPTY_THRESH (2)
    ) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .rinc      (rinc),
        .rundf_clr (rundf_clr),
        .rq2_wptr  (rq2_wptr),
        .rptr      (rptr),
        .raddr     (raddr),
        .rempty    (rempty),
        .raempty   (raempty),
        .rlevel    (rlevel),
        .rundf     (rundf)
    );

    always #5 rclk = ~rclk;

    function automatic logic [4:0] g(input int n);
        logic [4:0] b;
        b = n[4:0];
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s vec%0d: got %0h want %0h", name, id, act, req);
        end
    endtask

    // Monitor: every edge that has an outstanding expectation is checked just after it.
    always @(posedge rclk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("rptr",    e.id, 32'(rptr),    32'(e.rptr));
            chk("raddr",   e.id, 32'(raddr),   32'(e.raddr));
            chk("rempty",  e.id, 32'(rempty),  32'(e.rempty));
            chk("raempty", e.id, 32'(raempty), 32'(e.raempty));
            chk("rlevel",  e.id, 32'(rlevel),  32'(e.rlevel));
            chk("rundf",   e.id, 32'(rundf),   32'(e.rundf));
        end
    end

    task automatic step(input logic rst, input logic inc, input logic clr, input logic [4:0] wg,
                        input logic [4:0] e_rptr, input logic [3:0] e_raddr, input logic e_empty,
                        input logic e_aempty, input logic [4:0] e_lvl, input logic e_undf);
        exp_t e;
        @(negedge rclk);
        rrst      = rst;
        rinc      = inc;
        rundf_clr = clr;
        rq2_wptr  = wg;
        e.rptr    = e_rptr;
        e.raddr   = e_raddr;
        e.rempty  = e_empty;
        e.raempty = e_aempty;
        e.rlevel  = e_lvl;
        e.rundf   = e_undf;
        e.id      = vec_id;
        vec_id++;
        q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int guard;
        rrst = 1'b1; rinc = 1'b0; rundf_clr = 1'b0; rq2_wptr = '0;

        // 1. reset with rinc high and a non-zero write pointer
        step(1, 1, 0, 5'b00010, 5'b00000, 4'd0, 1, 1, 5'd0, 0);

        // 2. three words arrive, then drain
        step(0, 0, 0, 5'b00010, 5'b00000, 4'd0, 0, 0, 5'd3, 0);
        step(0, 1, 0, 5'b00010, 5'b00001, 4'd1, 0, 1, 5'd2, 0);
        step(0, 1, 0, 5'b00010, 5'b00011, 4'd2, 0, 1, 5'd1, 0);
        step(0, 1, 0, 5'b00010, 5'b00010, 4'd3, 1, 1, 5'd0, 0);

        // 3. underflow: pointer holds, flag sticks, set beats clear, clear alone works
        step(0, 1, 0, 5'b00010, 5'b00010, 4'd3, 1, 1, 5'd0, 1);
        step(0, 0, 0, 5'b00010, 5'b00010, 4'd3, 1, 1, 5'd0, 1);
        step(0, 1, 1, 5'b00010, 5'b00010, 4'd3, 1, 1, 5'd0, 1);
        step(0, 0, 1, 5'b00010, 5'b00010, 4'd3, 1, 1, 5'd0, 0);

        // 4. full FIFO from pointer 0, drain 16 with address wrap
        step(1, 0, 0, 5'b00000, 5'b00000, 4'd0, 1, 1, 5'd0, 0);
        step(0, 0, 0, 5'b11000, 5'b00000, 4'd0, 0, 0, 5'd16, 0);
        for (int k = 1; k <= 16; k++) begin
            step(0, 1, 0, 5'b11000, g(k), 4'(k), (k == 16), ((16 - k) <= 2), 5'(16 - k), 0);
        end
        step(0, 0, 0, 5'b10000, 5'b11000, 4'd0, 0, 0, 5'd15, 0);
        for (int k = 17; k <= 31; k++) begin
            step(0, 1, 0, 5'b10000, g(k), 4'(k), (k == 31), ((31 - k) <= 2), 5'(31 - k), 0);
        end
        step(0, 0, 0, 5'b00000, 5'b10000, 4'd15, 0, 1, 5'd1, 0);
        step(0, 1, 0, 5'b00000, 5'b00000, 4'd0, 1, 1, 5'd0, 0);

        // 5. reset while holding 5 words and reading
        step(0, 0, 0, 5'b00111, 5'b00000, 4'd0, 0, 0, 5'd5, 0);
        step(1, 1, 0, 5'b00111, 5'b00000, 4'd0, 1, 1, 5'd0, 0);

        // 6. write and read on the same edge keep the level constant
        step(0, 0, 0, 5'b00010, 5'b00000, 4'd0, 0, 0, 5'd3, 0);
        step(0, 1, 0, 5'b00110, 5'b00001, 4'd1, 0, 0, 5'd3, 0);

        @(negedge rclk);
        rinc = 1'b0;
        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            @(negedge rclk);
            guard++;
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rptr_empty.md
Name: rptr_empty

Overview:
Read-side pointer and flag logic for the dual-clock FIFO. It is the counterpart of the write-pointer/full block and lives entirely in the read clock domain. It keeps the binary and Gray read pointers and drives the RAM read address. It compares against the write pointer (Gray-coded, already double-synchronized into this domain) to produce registered empty and almost-empty flags, a fill level and a sticky underflow flag.

Parameters:
ADDRSIZEL, 4, FIFO address width; depth = 2^ADDRSIZEL; pointers are ADDRSIZEL+1 bits (extra wrap bit).
AEMPTY_THRESH, 2, raempty asserted when fill level <= this value; legal range 0..2^ADDRSIZEL.

Ports:
rclk  in  1  read-domain clock; all state updates on rising edge.
rrst  in  1  synchronous, active-high reset.
rinc  in  1  read request; a word is consumed only if rempty=0 in the same cycle.
rundf_clr  in  1  clears the sticky underflow flag.
rq2_wptr  in  ADDRSIZEL+1  write pointer, Gray, synchronized to rclk.
rptr  out  ADDRSIZEL+1  registered Gray read pointer, to the write-domain synchronizer.
raddr  out  ADDRSIZEL  RAM read address = low ADDRSIZEL bits of binary read pointer.
rempty  out  1  registered empty flag.
raempty  out  1  registered almost-empty flag.
rlevel  out  ADDRSIZEL+1  registered fill level, 0..2^ADDRSIZEL.
rundf  out  1  sticky underflow: rinc seen while rempty=1.

Behaviour:
- Clock and reset: one clock, rclk. Reset rrst is synchronous and active-high. All registers update only on the rising edge of rclk, reset included.
- Reset values: rbin=0, rptr=0, raddr=0, rempty=1, raempty=1, rlevel=0, rundf=0. rrst overrides every other input in that cycle.
- Pointer advance:
  - rbnext = rbin + (rinc & ~rempty), modulo 2^(ADDRSIZEL+1).
  - rgnext = (rbnext >> 1) ^ rbnext.
  - Register: rbin <= rbnext, rptr <= rgnext.
- raddr is combinational from the rbin register (no extra latency). It therefore points at the next word to be read.
- Empty: rempty <= (rgnext == rq2_wptr). Empty is flagged on the same edge the last word's read is committed.
- Level:
  - wbin_s = gray2bin(rq2_wptr).
  - rlevel <= (wbin_s - rbnext) modulo 2^(ADDRSIZEL+1).
  - Updates every cycle, so new writes become visible the cycle after rq2_wptr changes.
  - The level is pessimistic, by synchronizer lag, never optimistic.
- Almost-empty: raempty <= ((wbin_s - rbnext) <= AEMPTY_THRESH). It is computed from the same next-level value, so it is coherent with rlevel in the same cycle.
- Underflow:
  - If rinc=1 and rempty=1, the pointer holds and rundf <= 1 on the next edge.
  - rundf_clr=1 clears rundf. If a set and a clear occur in the same cycle, the set wins.
- Wrap:
  - raddr wraps from 2^ADDRSIZEL-1 to 0 while the MSB of rbin toggles.
  - rbin wraps from 2^(ADDRSIZEL+1)-1 to 0 with no special case.
  - Gray encoding guarantees rptr changes exactly one bit per read.
- Full FIFO: rlevel = 2^ADDRSIZEL is legal and is reported exactly. Reads proceed normally.
- Illegal input: a synchronized level above 2^ADDRSIZEL cannot occur in a correct system. It is not checked; the arithmetic result is passed through.
- Latency: rinc to rptr/raddr/rempty/rlevel update is 1 cycle. rq2_wptr change to rempty/rlevel update is 1 cycle.

Decomposition:
- Shared package fifo_pkg:
  - functions bin2gray(x) and gray2bin(x), sized by ADDRSIZEL;
  - constant FIFO_DEPTH = 2^ADDRSIZEL.
  - The write side reuses the same package.
- One natural combinational sub-module, gray2bin, instantiated for the rq2_wptr conversion: prefix-XOR from the MSB down.

Test Plan (ADDRSIZEL=4, AEMPTY_THRESH=2):
1. Reset: hold rrst=1 one edge with rinc=1 and rq2_wptr=5'b00010 -> rptr=0, raddr=0, rempty=1, raempty=1, rlevel=0, rundf=0.
2. Basic drain:
   - Stimulus: rq2_wptr=Gray(3)=5'b00010, rinc=0.
   - Next edge: rempty=0, rlevel=3, raempty=0.
   - Then rinc=1 for 3 cycles: raddr steps 0,1,2.
   - Required response: rlevel 2, 1, 0, with raempty=1 from the first read on; rempty=1 after the 3rd read; rptr=5'b00010.
3. Underflow:
   - Stimulus: with rempty=1, pulse rinc=1.
   - Required response: rbin and rptr unchanged; rundf=1 next edge and held.
   - Then rundf_clr=1 with rinc=1 on empty in the same cycle -> rundf stays 1.
   - Then rundf_clr=1 alone -> rundf=0.
4. Full and wrap:
   - Stimulus: rq2_wptr=Gray(16)=5'b11000.
   - Required response: rlevel=16, rempty=0.
   - Read 16 words: raddr wraps 15->0, final rptr=5'b11000, rempty=1.
   - Advance rq2_wptr to Gray(31) and read 15, then rq2_wptr=Gray(0) and read 1: rbin wraps 31->0, rptr=0, rempty=1.
5. Reset mid-operation: rlevel=5, rinc=1, rrst=1 on the same edge -> all outputs return to reset values; rinc is ignored.
6. Simultaneous write/read: rlevel=3 and rq2_wptr advances by 1 in the same cycle as a read -> rlevel stays 3, rempty=0; raddr advances by 1.
